// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multicycle controller: opcodes, FSM state
// encoding, ALU operation codes and datapath select codes.
package rv_ctrl_pkg;

    // Opcodes the controller executes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation codes; the ALU decodes the same values
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Register-file write data source
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A source
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B source
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // Immediate format is a pure function of the opcode, independent of state
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and status flags in,
// mux selects, enables and ALU operation out.
interface mc_ctrl_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [2:0] alu_ctrl;
    logic       illegal_instr;

    // Controller end
    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_ctrl,
               illegal_instr
    );

    // Datapath end
    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_ctrl,
               illegal_instr
    );
endinterface

// File: rtl/alu_decoder.sv
// ALU operation decode for R- and I-type instructions. Shift and sltu/xor
// funct3 values are flagged unsupported so the FSM can trap them in DECODE.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_ctrl,
    output logic       unsupported
);

    // funct3 -> ALU op; only R-type (op5=1) can subtract, so addi never does
    always_comb begin
        alu_ctrl    = ALU_ADD;
        unsupported = 1'b0;
        case (funct3)
            3'b000:  alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b110:  alu_ctrl = ALU_OR;
            3'b111:  alu_ctrl = ALU_AND;
            default: unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control unit. Outputs are decoded combinationally from
// the current state (plus mem_ready/zero where a state needs them); all
// write enables are held low while rst is asserted so a reset mid-access
// cannot leak a write.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC, wait for mem_ready
// DECODE   | read registers, OldPC+imm -> ALUOut, classify opcode
// MEMADR   | rs1+imm -> ALUOut (load/store address)
// MEMREAD  | read memory at ALUOut, wait for mem_ready
// MEMWB    | memory data -> rd
// MEMWRITE | write memory at ALUOut, wait for mem_ready
// EXECUTER | rs1 op rs2 -> ALUOut
// EXECUTEI | rs1 op imm -> ALUOut
// ALUWB    | ALUOut -> rd
// BEQ      | rs1-rs2, branch target in ALUOut -> PC when zero
// JAL      | jump target -> PC, OldPC+4 -> ALUOut for the link write
module mc_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic           clk,
    input  logic           rst,
    mc_ctrl_fsm_if.master  ctrl
);

    state_t     state_q;
    state_t     state_d;

    logic [2:0] dec_alu_ctrl;
    logic       dec_unsupported;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [2:0] alu_ctrl;
    logic       illegal_instr;

    alu_decoder u_alu_decoder (
        .op5         (ctrl.op[5]),
        .funct3      (ctrl.funct3),
        .funct7b5    (ctrl.funct7b5),
        .alu_ctrl    (dec_alu_ctrl),
        .unsupported (dec_unsupported)
    );

    // Next-state and per-state output decode; enables gated off during reset
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        reg_write     = 1'b0;
        alu_ctrl      = ALU_ADD;
        illegal_instr = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = ctrl.mem_ready;
                pc_write   = ctrl.mem_ready;
                if (ctrl.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (ctrl.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (dec_unsupported) begin
                            illegal_instr = 1'b1;
                            state_d       = S_FETCH;
                        end else begin
                            state_d = S_EXECUTER;
                        end
                    end
                    OP_ITYPE: begin
                        if (dec_unsupported) begin
                            illegal_instr = 1'b1;
                            state_d       = S_FETCH;
                        end else begin
                            state_d = S_EXECUTEI;
                        end
                    end
                    OP_BRANCH: begin
                        if (ctrl.funct3 == 3'b000) begin
                            state_d = S_BEQ;
                        end else begin
                            illegal_instr = 1'b1;
                            state_d       = S_FETCH;
                        end
                    end
                    OP_JAL: state_d = S_JAL;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = ctrl.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (ctrl.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ctrl.mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_ctrl  = dec_alu_ctrl;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = dec_alu_ctrl;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_ctrl   = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write   = ctrl.zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_ctrl   = ALU_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase

        if (rst) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) state_q <= RESET_STATE;
        else     state_q <= state_d;
    end

    assign ctrl.pc_write      = pc_write;
    assign ctrl.adr_src       = adr_src;
    assign ctrl.mem_write     = mem_write;
    assign ctrl.ir_write      = ir_write;
    assign ctrl.result_src    = result_src;
    assign ctrl.alu_src_a     = alu_src_a;
    assign ctrl.alu_src_b     = alu_src_b;
    assign ctrl.imm_src       = imm_src_of(ctrl.op);
    assign ctrl.reg_write     = reg_write;
    assign ctrl.alu_ctrl      = alu_ctrl;
    assign ctrl.illegal_instr = illegal_instr;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: each instruction is expanded into the sequence of
// phases it should pass through (with its memory stall schedule) and every
// cycle's full output vector is compared against the phase's expected value.
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if ifc ();

    mc_ctrl_fsm dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ifc)
    );

    typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_BEQ, P_JAL} ph_t;
    typedef struct {
        ph_t  ph;
        logic mr;
    } step_t;

    step_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011, 7'b0100011, 7'b1101111: return 1'b1;
            7'b0110011, 7'b0010011: return (f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111);
            7'b1100011: return (f3 == 3'b000);
            default: return 1'b0;
        endcase
    endfunction

    // Packed as {pc_write, adr_src, mem_write, ir_write, result_src,
    //            alu_src_a, alu_src_b, imm_src, reg_write, alu_ctrl, illegal}
    function automatic logic [16:0] expect_vec(input ph_t ph, input logic [6:0] op,
                                               input logic [2:0] f3, input logic f7b5,
                                               input logic zero, input logic mr);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] alu, aop;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
        case (op)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        case (f3)
            3'b000:  aop = (op[5] && f7b5) ? 3'b001 : 3'b000;
            3'b010:  aop = 3'b101;
            3'b110:  aop = 3'b011;
            3'b111:  aop = 3'b010;
            default: aop = 3'b000;
        endcase
        case (ph)
            P_F:   begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            P_D:   begin sa = 2'b01; sb = 2'b01; ill = !legal(op, f3); end
            P_MA:  begin sa = 2'b10; sb = 2'b01; end
            P_MR:  adr = 1;
            P_MWB: begin res = 2'b01; rw = 1; end
            P_MW:  begin adr = 1; mw = 1; end
            P_ER:  begin sa = 2'b10; sb = 2'b00; alu = aop; end
            P_EI:  begin sa = 2'b10; sb = 2'b01; alu = aop; end
            P_AWB: rw = 1;
            P_BEQ: begin sa = 2'b10; alu = 3'b001; pcw = zero; end
            P_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, res, sa, sb, imm, rw, alu, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {ifc.pc_write, ifc.adr_src, ifc.mem_write, ifc.ir_write, ifc.result_src,
                ifc.alu_src_a, ifc.alu_src_b, ifc.imm_src, ifc.reg_write, ifc.alu_ctrl,
                ifc.illegal_instr};
    endfunction

    // Enables only: {pc_write, ir_write, mem_write, reg_write, illegal_instr}
    function automatic logic [4:0] observed_en();
        return {ifc.pc_write, ifc.ir_write, ifc.mem_write, ifc.reg_write, ifc.illegal_instr};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input ph_t ph, input logic mr);
        step_t s;
        s.ph = ph;
        s.mr = mr;
        q.push_back(s);
    endtask

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input int fst, input int mst);
        q.delete();
        for (int i = 0; i < fst; i++) push(P_F, 1'b0);
        push(P_F, 1'b1);
        push(P_D, rnd_bit());
        if (!legal(op, f3)) return;
        case (op)
            7'b0000011: begin
                push(P_MA, rnd_bit());
                for (int i = 0; i < mst; i++) push(P_MR, 1'b0);
                push(P_MR, 1'b1);
                push(P_MWB, rnd_bit());
            end
            7'b0100011: begin
                push(P_MA, rnd_bit());
                for (int i = 0; i < mst; i++) push(P_MW, 1'b0);
                push(P_MW, 1'b1);
            end
            7'b0110011: begin push(P_ER, rnd_bit()); push(P_AWB, rnd_bit()); end
            7'b0010011: begin push(P_EI, rnd_bit()); push(P_AWB, rnd_bit()); end
            7'b1100011: push(P_BEQ, rnd_bit());
            default:    begin push(P_JAL, rnd_bit()); push(P_AWB, rnd_bit()); end
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 after the instruction's last cycle
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7b5, input logic zero, input int fst, input int mst,
                             input int exp_cycles);
        logic [16:0] exp_v;
        build(op, f3, fst, mst);
        if (exp_cycles > 0) begin
            checks++;
            assert (q.size() == exp_cycles) else begin
                errors++;
                $error("FAIL %s latency: model %0d cycles, required %0d", name, q.size(), exp_cycles);
            end
        end
        ifc.op = op; ifc.funct3 = f3; ifc.funct7b5 = f7b5; ifc.zero = zero;
        foreach (q[i]) begin
            ifc.mem_ready = q[i].mr;
            #2;
            exp_v = expect_vec(q[i].ph, op, f3, f7b5, zero, q[i].mr);
            checks++;
            assert (observed() === exp_v) else begin
                errors++;
                $error("FAIL %s cyc%0d %s: got %h expected %h", name, i, q[i].ph.name(), observed(), exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [6:0] op;
        logic [6:0] ops[8];
        logic [16:0] exp_v;

        ifc.op = 7'b0110011; ifc.funct3 = 3'b000; ifc.funct7b5 = 1'b0;
        ifc.zero = 1'b0; ifc.mem_ready = 1'b1;
        rst = 1'b1;

        // Enables stay low while reset is held, even with mem_ready=1 in FETCH
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            assert (observed_en() === 5'b0) else begin
                errors++;
                $error("FAIL reset_en%0d: got %b expected 00000", i, observed_en());
            end
        end
        rst = 1'b0;

        run_instr("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4);
        run_instr("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 4);
        run_instr("addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 4);
        run_instr("ori",   7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 4);
        run_instr("slti",  7'b0010011, 3'b010, 1'b0, 1'b0, 0, 0, 4);
        run_instr("andr",  7'b0110011, 3'b111, 1'b0, 1'b0, 1, 0, 5);
        run_instr("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2, 7);
        run_instr("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1, 5);
        run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3);
        run_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 3);
        run_instr("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 4);
        run_instr("lui",   7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, 2);
        run_instr("xor",   7'b0110011, 3'b100, 1'b0, 1'b0, 0, 0, 2);
        run_instr("srli",  7'b0010011, 3'b101, 1'b0, 1'b0, 0, 0, 2);
        run_instr("bne",   7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 2);

        // Reset during MEMWRITE: write strobe drops immediately, FETCH after edge
        ifc.op = 7'b0100011; ifc.funct3 = 3'b010; ifc.zero = 1'b0;
        ifc.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        ifc.mem_ready = 1'b0;
        #2;
        checks++;
        assert (ifc.mem_write === 1'b1) else begin
            errors++;
            $error("FAIL rst_mw_pre: got mem_write=%b expected 1", ifc.mem_write);
        end
        rst = 1'b1;
        ifc.mem_ready = 1'b1;
        #1;
        checks++;
        assert (observed_en() === 5'b0) else begin
            errors++;
            $error("FAIL rst_mw_same: got %b expected 00000", observed_en());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ifc.mem_ready = 1'b0;
        #2;
        exp_v = expect_vec(P_F, 7'b0100011, 3'b010, ifc.funct7b5, 1'b0, 1'b0);
        checks++;
        assert (observed() === exp_v) else begin
            errors++;
            $error("FAIL rst_mw_fetch: got %h expected %h", observed(), exp_v);
        end
        @(posedge clk); #1;

        // Randomized instruction stream
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b0110111; ops[7] = 7'b0000000;
        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 7'b0000000) op = 7'($urandom_range(0, 127));
            run_instr("rand", op, 3'($urandom_range(0, 7)), rnd_bit(), rnd_bit(),
                      $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
